cell_mem_arbiter: RTL
=====================

// Module: cell_mem_arbiter
// PURPOSE
//  Sole owner of the single-port cell RAM (M*N cells, 1 bit each, 1-cycle synchronous read).
//  Shares it between three requesters: display scan (read), evolution engine (read/write) and
//  manual single-cell toggle (read-modify-write, runs its own FSM).
//  One memory op per cycle; all memory-side outputs registered.
// PARAMETERS
//  P_PARAM_M  5   rows of the cell grid
//  P_PARAM_N  5   columns of the cell grid
//  WIDTH      12  address width; valid addresses 0 .. M*N-1
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  rst_n        in   1      synchronous reset, active-low
//  disp_req     in   1      display read request, held until granted
//  disp_addr    in   WIDTH  display read address
//  disp_gnt     out  1      comb; disp_req&disp_gnt at posedge = accepted
//  disp_rvalid  out  1      disp_rdata valid this cycle
//  disp_rdata   out  1      cell value for display
//  evo_req      in   1      evolution request, held until granted
//  evo_we       in   1      1 = write, 0 = read
//  evo_addr     in   WIDTH  evolution address
//  evo_wdata    in   1      evolution write data
//  evo_gnt      out  1      comb; evo_req&evo_gnt at posedge = accepted
//  evo_rvalid   out  1      evo_rdata valid (reads only)
//  evo_rdata    out  1      cell value for evolution engine
//  modify       in   1      manual toggle request; acted on at rising edge
//  modify_addr  in   WIDTH  cell to toggle, sampled at the modify rising edge
//  man_busy     out  1      manual RMW in progress
//  man_done     out  1      1-cycle pulse when toggle write has been issued
//  mem_addr     out  WIDTH  RAM address (registered)
//  mem_wden     out  1      RAM write enable (registered)
//  mem_wdata    out  1      RAM write data (registered)
//  mem_rdata    in   1      RAM read data, valid 1 cycle after mem_addr presented
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): mem_addr=0, mem_wden=0, mem_wdata=0, all gnt/rvalid/rdata=0,
//   man_busy=0, man_done=0, manual FSM -> M_IDLE, edge register prev_modify=0, disp_last=0.
//   Reset mid-operation drops any pending/in-flight op; no write is issued afterwards.
//  Accept at cycle t -> mem_addr/mem_wden/mem_wdata driven in t+1 -> for reads, *_rvalid=1
//   and *_rdata=mem_rdata in t+2 (read latency 2 from accept). Pipelined: one accept per cycle.
//  rvalid routing tracked by a 2-stage tag pipe (none/disp/evo/man); mem_wden=0 when no accept.
//  Manual FSM (edge: modify=1 & prev_modify=0):
//   M_IDLE  -edge & addr<M*N-> M_RD (latch addr, man_busy=1); addr>=M*N or edge while busy: ignored
//   M_RD    -manual read accepted-> M_WAIT
//   M_WAIT  (1 cycle, read in flight) -> M_WB
//   M_WB    rdata captured; issue write of ~rdata, same addr, unconditionally -> M_IDLE,
//           man_done=1 for that cycle, man_busy=0 next cycle.
//  Priority each cycle (one winner):
//   1. lock: manual FSM in M_WAIT or M_WB -> only manual may use the RAM (M_WAIT: no op);
//      disp_gnt=evo_gnt=0. Guarantees no other write between manual read and write.
//   2. display, unless disp_last=1 and (M_RD or evo_req) -> anti-starvation: display never
//      wins two consecutive cycles while another requester waits.
//   3. manual read (M_RD).  4. evolution.
//  disp_last=1 iff display accepted previous cycle.
//  Gnt is combinational from state+requests, never depends on addr/data; requester may
//   drop req freely when not granted.
//  Out-of-range disp/evo addresses are forwarded unchanged (requester's responsibility).
// TESTING
//  T1 disp_req=1 addr=7, RAM[7]=1, idle -> disp_gnt=1 at t, mem_addr=7 t+1, disp_rvalid=1 rdata=1 t+2.
//  T2 modify 0->1 addr=3, RAM[3]=0, no other req -> read 3, write mem_wdata=1 addr 3
//     4 cycles after edge, man_done 1 cycle; held modify=1 causes no second toggle.
//  T3 disp_req held high + evo_req held high -> grants alternate disp,evo,disp,evo; no stalls.
//  T4 modify edge addr=4 then evo_req we=1 addr=4 every cycle -> evo_gnt=0 during M_WAIT/M_WB;
//     RAM[4] = toggled value before evo write lands; evo write accepted right after.
//  T5 modify edge with addr=25 (M=N=5) -> no RAM access, man_done never pulses;
//     second edge while man_busy -> ignored, exactly one write.
//  T6 rst_n=0 in M_WAIT -> next cycle mem_wden=0, man_busy=0; no toggle write ever issued.

Source files
------------

// File: rtl/cell_mem_arbiter.sv
// Owner of the single-port cell RAM: arbitrates display reads, evolution read/write and a
// manual read-modify-write toggle, issuing at most one registered memory op per cycle.
module cell_mem_arbiter #(
  parameter int P_PARAM_M = 5,
  parameter int P_PARAM_N = 5,
  parameter int WIDTH     = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_req,
  input  logic [WIDTH-1:0] disp_addr,
  output logic             disp_gnt,
  output logic             disp_rvalid,
  output logic             disp_rdata,
  input  logic             evo_req,
  input  logic             evo_we,
  input  logic [WIDTH-1:0] evo_addr,
  input  logic             evo_wdata,
  output logic             evo_gnt,
  output logic             evo_rvalid,
  output logic             evo_rdata,
  input  logic             modify,
  input  logic [WIDTH-1:0] modify_addr,
  output logic             man_busy,
  output logic             man_done,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_wden,
  output logic             mem_wdata,
  input  logic             mem_rdata
);

  localparam logic [WIDTH-1:0] CELLS = WIDTH'(P_PARAM_M * P_PARAM_N);

  typedef enum logic [1:0] {M_IDLE, M_RD, M_WAIT, M_WB} man_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_EVO, TAG_MAN} tag_t;

  man_state_t       state_r, state_s;
  tag_t             tag1_r, tag2_r, op_tag_s;
  logic             prev_modify_r, disp_last_r, man_busy_r, man_done_r;
  logic [WIDTH-1:0] man_addr_r, mem_addr_r, op_addr_s;
  logic             mem_wden_r, mem_wdata_r;
  logic             lock_s, disp_gnt_s, evo_gnt_s, man_rd_s;
  logic             op_valid_s, op_we_s, op_wdata_s;

  // Grant arbitration; M_WAIT/M_WB lock the RAM so nothing lands between manual read and write.
  always_comb begin
    lock_s     = (state_r == M_WAIT) || (state_r == M_WB);
    disp_gnt_s = 1'b0;
    evo_gnt_s  = 1'b0;
    man_rd_s   = 1'b0;
    if (lock_s) begin
      disp_gnt_s = 1'b0;
    end else begin
      disp_gnt_s = disp_req && !(disp_last_r && ((state_r == M_RD) || evo_req));
      man_rd_s   = (state_r == M_RD) && !disp_gnt_s;
      evo_gnt_s  = evo_req && !disp_gnt_s && (state_r != M_RD);
    end
  end

  // Manual toggle next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      M_IDLE: begin
        if (modify && !prev_modify_r && (modify_addr < CELLS)) state_s = M_RD;
        else state_s = M_IDLE;
      end
      M_RD: begin
        if (man_rd_s) state_s = M_WAIT;
        else state_s = M_RD;
      end
      M_WAIT:  state_s = M_WB;
      M_WB:    state_s = M_IDLE;
      default: state_s = M_IDLE;
    endcase
  end

  // Select the single memory op for this cycle.
  always_comb begin
    op_valid_s = 1'b0;
    op_we_s    = 1'b0;
    op_wdata_s = 1'b0;
    op_addr_s  = mem_addr_r;
    op_tag_s   = TAG_NONE;
    if (disp_gnt_s) begin
      op_valid_s = 1'b1;
      op_addr_s  = disp_addr;
      op_tag_s   = TAG_DISP;
    end else if (man_rd_s) begin
      op_valid_s = 1'b1;
      op_addr_s  = man_addr_r;
      op_tag_s   = TAG_MAN;
    end else if (evo_gnt_s) begin
      op_valid_s = 1'b1;
      op_we_s    = evo_we;
      op_wdata_s = evo_wdata;
      op_addr_s  = evo_addr;
      op_tag_s   = evo_we ? TAG_NONE : TAG_EVO;
    end else if (state_r == M_WB) begin
      // mem_rdata here is the manual read result (tag2 == TAG_MAN)
      op_valid_s = 1'b1;
      op_we_s    = 1'b1;
      op_wdata_s = ~mem_rdata;
      op_addr_s  = man_addr_r;
    end else begin
      op_valid_s = 1'b0;
    end
  end

  // State, edge detect, memory-side registers and read tag pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= M_IDLE;
      prev_modify_r <= 1'b0;
      disp_last_r   <= 1'b0;
      man_addr_r    <= {WIDTH{1'b0}};
      mem_addr_r    <= {WIDTH{1'b0}};
      mem_wden_r    <= 1'b0;
      mem_wdata_r   <= 1'b0;
      tag1_r        <= TAG_NONE;
      tag2_r        <= TAG_NONE;
      man_busy_r    <= 1'b0;
      man_done_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      prev_modify_r <= modify;
      disp_last_r   <= disp_gnt_s;
      if ((state_r == M_IDLE) && (state_s == M_RD)) man_addr_r <= modify_addr;
      if (op_valid_s) mem_addr_r <= op_addr_s;
      mem_wden_r    <= op_valid_s && op_we_s;
      mem_wdata_r   <= op_valid_s && op_we_s && op_wdata_s;
      tag1_r        <= op_tag_s;
      tag2_r        <= tag1_r;
      man_busy_r    <= (state_s != M_IDLE);
      man_done_r    <= (state_r == M_WB);
    end
  end

  assign disp_gnt    = disp_gnt_s;
  assign evo_gnt     = evo_gnt_s;
  assign disp_rvalid = (tag2_r == TAG_DISP);
  assign evo_rvalid  = (tag2_r == TAG_EVO);
  assign disp_rdata  = disp_rvalid && mem_rdata;
  assign evo_rdata   = evo_rvalid && mem_rdata;
  assign man_busy    = man_busy_r;
  assign man_done    = man_done_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wden    = mem_wden_r;
  assign mem_wdata   = mem_wdata_r;

endmodule
